// File: rtl/test_prog_gen.sv
// Purpose: loadable program sequencer driving a node's instruction and port stimulus, checking its response.
// Latency: start presents entry 0 one cycle later; each accepted entry advances the next cycle.
// Backpressure: instr_ready low holds every output; stop aborts to IDLE ahead of any acceptance.
module test_prog_gen #(
   parameter int DEPTH   = 16,
   parameter int NCH     = 4,
   parameter int DATA_W  = 8,
   parameter int INSTR_W = 18
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_en,
   input  logic [$clog2(DEPTH)-1:0]  load_addr,
   input  logic [INSTR_W-1:0]        load_instr,
   input  logic [NCH*DATA_W-1:0]     load_data,
   input  logic [NCH-1:0]            load_mask,
   input  logic                      load_chk,
   input  logic [DATA_W-1:0]         load_exp,
   input  logic [$clog2(DEPTH+1)-1:0] prog_len,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      loop_en,
   input  logic                      instr_ready,
   input  logic [DATA_W-1:0]         in0,
   output logic [INSTR_W-1:0]        instr,
   output logic [NCH*DATA_W-1:0]     out_bus,
   output logic [$clog2(DEPTH)-1:0]  pc,
   output logic                      busy,
   output logic                      done,
   output logic [7:0]                loop_cnt,
   output logic [7:0]                err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [INSTR_W-1:0] NOP = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                 state_q, state_d;
   logic [INSTR_W-1:0]     instr_q, instr_d;
   logic [NCH*DATA_W-1:0]  out_bus_q, out_bus_d;
   logic [AW-1:0]          pc_q, pc_d;
   logic                   done_q, done_d;
   logic [7:0]             loop_cnt_q, loop_cnt_d;
   logic [7:0]             err_cnt_q, err_cnt_d;

   // Program storage; deliberately not reset so a reset mid-run keeps the program.
   logic [INSTR_W-1:0]     mem_instr_q [DEPTH];
   logic [NCH*DATA_W-1:0]  mem_data_q  [DEPTH];
   logic [NCH-1:0]         mem_mask_q  [DEPTH];
   logic                   mem_chk_q   [DEPTH];
   logic [DATA_W-1:0]      mem_exp_q   [DEPTH];

   logic [LW-1:0]          len;
   logic                   last;
   logic                   present;
   logic [AW-1:0]          sel;

   // Clamp the requested length to the storage depth; detect the final entry.
   always_comb begin
      len  = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
      last = ((LW+1)'(pc_q) + (LW+1)'(1)) >= (LW+1)'(len);
   end

   // Program writes are accepted only while idle; out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (load_en && (state_q == S_IDLE) && (32'(load_addr) < DEPTH)) begin
         mem_instr_q[load_addr] <= load_instr;
         mem_data_q[load_addr]  <= load_data;
         mem_mask_q[load_addr]  <= load_mask;
         mem_chk_q[load_addr]   <= load_chk;
         mem_exp_q[load_addr]   <= load_exp;
      end
   end

   // Next-state and output computation; "present" loads entry sel onto the outputs.
   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      out_bus_d  = out_bus_q;
      pc_d       = pc_q;
      done_d     = 1'b0;
      loop_cnt_d = loop_cnt_q;
      err_cnt_d  = err_cnt_q;
      present    = 1'b0;
      sel        = '0;

      case (state_q)
         S_IDLE: begin
            if (start && (len != '0)) begin
               present    = 1'b1;
               sel        = '0;
               err_cnt_d  = '0;
               loop_cnt_d = '0;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               instr_d = NOP;
               state_d = S_IDLE;
            end else if (instr_ready) begin
               if (mem_chk_q[pc_q] && (in0 != mem_exp_q[pc_q]) && (err_cnt_q != 8'hFF))
                  err_cnt_d = err_cnt_q + 8'd1;
               if (!last) begin
                  present = 1'b1;
                  sel     = pc_q + AW'(1);
               end else if (loop_en) begin
                  present    = 1'b1;
                  sel        = '0;
                  loop_cnt_d = loop_cnt_q + 8'd1;
               end else begin
                  instr_d = NOP;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (present) begin
         pc_d    = sel;
         instr_d = mem_instr_q[sel];
         for (int k = 0; k < NCH; k++) begin
            if (mem_mask_q[sel][k])
               out_bus_d[k*DATA_W +: DATA_W] = mem_data_q[sel][k*DATA_W +: DATA_W];
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         instr_q    <= NOP;
         out_bus_q  <= '1;
         pc_q       <= '0;
         done_q     <= 1'b0;
         loop_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         out_bus_q  <= out_bus_d;
         pc_q       <= pc_d;
         done_q     <= done_d;
         loop_cnt_q <= loop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign instr    = instr_q;
   assign out_bus  = out_bus_q;
   assign pc       = pc_q;
   assign busy     = (state_q == S_RUN);
   assign done     = done_q;
   assign loop_cnt = loop_cnt_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_test_prog_gen.sv
// Directed bench for test_prog_gen: table-driven run sequences plus hand-written corner cases.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived from the program loaded below.
module tb_test_prog_gen;

   logic        clk;
   logic        rst_n;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [17:0] load_instr;
   logic [31:0] load_data;
   logic [3:0]  load_mask;
   logic        load_chk;
   logic [7:0]  load_exp;
   logic [4:0]  prog_len;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic        instr_ready;
   logic [7:0]  in0;
   logic [17:0] instr;
   logic [31:0] out_bus;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic [7:0]  loop_cnt;
   logic [7:0]  err_cnt;

   int checks;
   int failures;

   test_prog_gen #(.DEPTH(16), .NCH(4), .DATA_W(8), .INSTR_W(18)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_en(load_en), .load_addr(load_addr), .load_instr(load_instr),
      .load_data(load_data), .load_mask(load_mask), .load_chk(load_chk),
      .load_exp(load_exp), .prog_len(prog_len), .start(start), .stop(stop),
      .loop_en(loop_en), .instr_ready(instr_ready), .in0(in0),
      .instr(instr), .out_bus(out_bus), .pc(pc), .busy(busy), .done(done),
      .loop_cnt(loop_cnt), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        start;
      logic        rdy;
      logic [17:0] e_instr;
      logic [3:0]  e_pc;
      logic        e_busy;
      logic        e_done;
      logic [31:0] e_bus;
   } vec_t;

   vec_t tbl [20];
   logic [17:0] prog_instr [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_entry(input logic [3:0] a, input logic [17:0] ins, input logic [7:0] d,
                             input logic [3:0] m, input logic c, input logic [7:0] e);
      load_en    = 1'b1;
      load_addr  = a;
      load_instr = ins;
      load_data  = {4{d}};
      load_mask  = m;
      load_chk   = c;
      load_exp   = e;
      step();
      load_en    = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [3:0] last_pc;
      checks = 0; failures = 0;
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_instr = '0; load_data = '0;
      load_mask = '0; load_chk = 1'b0; load_exp = '0; prog_len = '0; start = 1'b0;
      stop = 1'b0; loop_en = 1'b0; instr_ready = 1'b0; in0 = '0;

      prog_instr[0] = 18'h00400; prog_instr[1] = 18'h0CC00; prog_instr[2] = 18'h0D400;
      prog_instr[3] = 18'h09C00; prog_instr[4] = 18'h11000; prog_instr[5] = 18'h3FFFF;

      // Basic run, ready held high, then ready toggling 1,0,1,0...
      tbl[0]  = '{1'b1, 1'b1, 18'h00400, 4'd0, 1'b1, 1'b0, 32'hFFFFFF01};
      tbl[1]  = '{1'b0, 1'b1, 18'h0CC00, 4'd1, 1'b1, 1'b0, 32'hFFFF0201};
      tbl[2]  = '{1'b0, 1'b1, 18'h0D400, 4'd2, 1'b1, 1'b0, 32'hFF030201};
      tbl[3]  = '{1'b0, 1'b1, 18'h09C00, 4'd3, 1'b1, 1'b0, 32'h04030201};
      tbl[4]  = '{1'b0, 1'b1, 18'h11000, 4'd4, 1'b1, 1'b0, 32'h04030201};
      tbl[5]  = '{1'b0, 1'b1, 18'h3FFFF, 4'd5, 1'b1, 1'b0, 32'h04030201};
      tbl[6]  = '{1'b0, 1'b1, 18'h3FFFF, 4'd5, 1'b0, 1'b1, 32'h04030201};
      tbl[7]  = '{1'b0, 1'b0, 18'h3FFFF, 4'd5, 1'b0, 1'b0, 32'h04030201};
      tbl[8]  = '{1'b1, 1'b0, 18'h00400, 4'd0, 1'b1, 1'b0, 32'h04030201};
      tbl[9]  = '{1'b0, 1'b1, 18'h0CC00, 4'd1, 1'b1, 1'b0, 32'h04030201};
      tbl[10] = '{1'b0, 1'b0, 18'h0CC00, 4'd1, 1'b1, 1'b0, 32'h04030201};
      tbl[11] = '{1'b0, 1'b1, 18'h0D400, 4'd2, 1'b1, 1'b0, 32'h04030201};
      tbl[12] = '{1'b0, 1'b0, 18'h0D400, 4'd2, 1'b1, 1'b0, 32'h04030201};
      tbl[13] = '{1'b0, 1'b1, 18'h09C00, 4'd3, 1'b1, 1'b0, 32'h04030201};
      tbl[14] = '{1'b0, 1'b0, 18'h09C00, 4'd3, 1'b1, 1'b0, 32'h04030201};
      tbl[15] = '{1'b0, 1'b1, 18'h11000, 4'd4, 1'b1, 1'b0, 32'h04030201};
      tbl[16] = '{1'b0, 1'b0, 18'h11000, 4'd4, 1'b1, 1'b0, 32'h04030201};
      tbl[17] = '{1'b0, 1'b1, 18'h3FFFF, 4'd5, 1'b1, 1'b0, 32'h04030201};
      tbl[18] = '{1'b0, 1'b0, 18'h3FFFF, 4'd5, 1'b1, 1'b0, 32'h04030201};
      tbl[19] = '{1'b0, 1'b1, 18'h3FFFF, 4'd5, 1'b0, 1'b1, 32'h04030201};

      step();
      step();
      check("rst_instr", 32'(instr), 32'h3FFFF);
      check("rst_bus", out_bus, 32'hFFFFFFFF);
      check("rst_pc", 32'(pc), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_loop", 32'(loop_cnt), 0);
      check("rst_err", 32'(err_cnt), 0);
      rst_n = 1'b1;
      step();

      load_entry(4'd0, 18'h00400, 8'd1, 4'b0001, 1'b0, 8'h00);
      load_entry(4'd1, 18'h0CC00, 8'd2, 4'b0010, 1'b0, 8'h00);
      load_entry(4'd2, 18'h0D400, 8'd3, 4'b0100, 1'b0, 8'h00);
      load_entry(4'd3, 18'h09C00, 8'd4, 4'b1000, 1'b0, 8'h00);
      load_entry(4'd4, 18'h11000, 8'd0, 4'b0000, 1'b0, 8'h00);
      load_entry(4'd5, 18'h3FFFF, 8'd0, 4'b0000, 1'b0, 8'h00);
      check("idle_after_load", 32'(busy), 0);

      prog_len = 5'd6;
      for (int i = 0; i < 20; i++) begin
         start       = tbl[i].start;
         instr_ready = tbl[i].rdy;
         step();
         start = 1'b0;
         check($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].e_instr));
         check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
         check($sformatf("tbl%0d_bus", i), out_bus, tbl[i].e_bus);
      end

      // Loop mode: three-entry program, ten ready cycles, then stop.
      loop_en = 1'b1; prog_len = 5'd3; start = 1'b1; instr_ready = 1'b1;
      step();
      start = 1'b0;
      check("loop_pc0", 32'(pc), 0);
      check("loop_cnt0", 32'(loop_cnt), 0);
      for (int i = 1; i < 10; i++) begin
         step();
         check($sformatf("loop_pc%0d", i), 32'(pc), 32'(i % 3));
         check($sformatf("loop_done%0d", i), 32'(done), 0);
      end
      check("loop_cnt_end", 32'(loop_cnt), 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_instr", 32'(instr), 32'h3FFFF);
      check("stop_busy", 32'(busy), 0);
      check("stop_done", 32'(done), 0);
      check("stop_loop", 32'(loop_cnt), 3);
      check("stop_pc", 32'(pc), 0);
      step();
      check("stop_done_after", 32'(done), 0);

      // Response checks on entries 1 and 2.
      instr_ready = 1'b0; loop_en = 1'b0; prog_len = 5'd6;
      load_entry(4'd1, 18'h0CC00, 8'd2, 4'b0010, 1'b1, 8'h05);
      load_entry(4'd2, 18'h0D400, 8'd3, 4'b0100, 1'b1, 8'h07);
      in0 = 8'h00; start = 1'b1; instr_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      check("chk_pc1", 32'(pc), 1);
      in0 = 8'h05;
      step();
      check("chk_err_match", 32'(err_cnt), 0);
      in0 = 8'h06;
      step();
      check("chk_err_mismatch", 32'(err_cnt), 1);
      in0 = 8'h00;
      step();
      step();
      step();
      check("chk_done", 32'(done), 1);
      check("chk_err_final", 32'(err_cnt), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_err_clear", 32'(err_cnt), 0);
      check("restart_pc", 32'(pc), 0);

      // Asynchronous reset in the middle of the run at pc=2.
      step();
      step();
      check("pre_rst_pc", 32'(pc), 2);
      check("pre_rst_err", 32'(err_cnt), 1);
      rst_n = 1'b0;
      #2;
      check("arst_instr", 32'(instr), 32'h3FFFF);
      check("arst_bus", out_bus, 32'hFFFFFFFF);
      check("arst_pc", 32'(pc), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_err", 32'(err_cnt), 0);
      step();
      rst_n = 1'b1;
      instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("replay_instr%0d", i), 32'(instr), 32'(prog_instr[i]));
         step();
      end
      check("replay_done", 32'(done), 1);
      check("replay_err", 32'(err_cnt), 2);
      check("replay_bus", out_bus, 32'h04030201);

      // prog_len = 0 is ignored.
      prog_len = 5'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("len0_busy", 32'(busy), 0);
      check("len0_instr", 32'(instr), 32'h3FFFF);

      // prog_len beyond depth clamps to 16 entries.
      instr_ready = 1'b0;
      for (int i = 6; i < 16; i++)
         load_entry(4'(i), 18'h00100 + 18'(i), 8'd0, 4'b0000, 1'b0, 8'h00);
      prog_len = 5'd20; instr_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      cnt = 0; last_pc = '0;
      while (!done && cnt < 40) begin
         if (busy) last_pc = pc;
         step();
         cnt++;
      end
      check("clamp_cycles", 32'(cnt), 16);
      check("clamp_last_pc", 32'(last_pc), 15);

      // A write during RUN must not change the program.
      prog_len = 5'd3; loop_en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      load_en = 1'b1; load_addr = 4'd1; load_instr = 18'h2AAAA; load_data = '0;
      load_mask = 4'b1111; load_chk = 1'b0; load_exp = '0;
      step();
      step();
      step();
      load_en = 1'b0;
      step();
      check("wr_run_pc", 32'(pc), 1);
      check("wr_run_instr", 32'(instr), 32'h0CC00);
      check("wr_run_bus", out_bus, 32'h04030201);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("wr_run_stop_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
